param_loader: RTL

PARAM_LOADER -- requirements
Module: param_loader

---
 rtl/param_loader_pkg.sv | 25 ++
 rtl/param_loader_bank.sv | 41 ++++
 rtl/param_loader.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/param_loader_pkg.sv
// Shared constants for the double-buffered parameter loader.
// Field codes, FSM state encoding and bank geometry.
package param_loader_pkg;

    localparam int NUM_CHANNELS = 16;
    localparam int WORD_W       = 16;
    localparam int CHAN_W       = 4;
    localparam int BANK_W       = NUM_CHANNELS * WORD_W;

    localparam logic [1:0] FIELD_AMP    = 2'd0;
    localparam logic [1:0] FIELD_OFFSET = 2'd1;
    localparam logic [1:0] FIELD_PHASE  = 2'd2;
    localparam logic [1:0] FIELD_CTRL   = 2'd3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_SWAP  = 2'd3;

    // Bit offset of a channel's word within a flat bank vector
    function automatic logic [7:0] word_base(input logic [CHAN_W-1:0] chan);
        return {chan, 4'b0000};
    endfunction

endpackage

// File: rtl/param_loader_bank.sv
// param_bank: 16x16 amp/offset/phaseword register file.
// Single-word write port plus a whole-bank parallel load.
module param_bank
    import param_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [1:0]        field,
    input  logic [CHAN_W-1:0] chan,
    input  logic [WORD_W-1:0] data,
    input  logic              load,
    input  logic [BANK_W-1:0] load_amps,
    input  logic [BANK_W-1:0] load_offsets,
    input  logic [BANK_W-1:0] load_phases,
    output logic [BANK_W-1:0] amps,
    output logic [BANK_W-1:0] offsets,
    output logic [BANK_W-1:0] phases
);

    // Bulk load wins over a word write; a write touches one lane only
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            amps    <= '0;
            offsets <= '0;
            phases  <= '0;
        end else if (load) begin
            amps    <= load_amps;
            offsets <= load_offsets;
            phases  <= load_phases;
        end else if (we) begin
            case (field)
                FIELD_AMP:    amps[word_base(chan) +: WORD_W]    <= data;
                FIELD_OFFSET: offsets[word_base(chan) +: WORD_W] <= data;
                FIELD_PHASE:  phases[word_base(chan) +: WORD_W]  <= data;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/param_loader.sv
// param_loader: shadow/live parameter banks with drained swap.
// Optional live-bank readback port under PARAM_READBACK_EN.
module param_loader
    import param_loader_pkg::*;
#(
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [1:0]               wr_field,
    input  logic [CHAN_W-1:0]        wr_chan,
    input  logic [WORD_W-1:0]        wr_data,
    input  logic                     commit,
`ifdef PARAM_READBACK_EN
    input  logic [1:0]               rd_field,
    input  logic [CHAN_W-1:0]        rd_chan,
    output logic [WORD_W-1:0]        rd_data,
`endif
    output logic signed [BANK_W-1:0] amps,
    output logic [BANK_W-1:0]        offsets,
    output logic [BANK_W-1:0]        phasewords,
    output logic                     active,
    output logic                     busy
);

    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic              shadow_en;
    logic              live_en;
    logic              accept;
    logic              swapping;
    logic [BANK_W-1:0] sh_amps;
    logic [BANK_W-1:0] sh_offsets;
    logic [BANK_W-1:0] sh_phases;
    logic [BANK_W-1:0] lv_amps;
    logic [BANK_W-1:0] lv_offsets;
    logic [BANK_W-1:0] lv_phases;

    assign wr_ready = (state != ST_SWAP);
    assign accept   = wr_valid && wr_ready;
    assign swapping = (state == ST_SWAP);

    param_bank u_shadow (
        .clk          (clk),
        .reset        (reset),
        .we           (accept),
        .field        (wr_field),
        .chan         (wr_chan),
        .data         (wr_data),
        .load         (1'b0),
        .load_amps    ('0),
        .load_offsets ('0),
        .load_phases  ('0),
        .amps         (sh_amps),
        .offsets      (sh_offsets),
        .phases       (sh_phases)
    );

    param_bank u_live (
        .clk          (clk),
        .reset        (reset),
        .we           (1'b0),
        .field        (FIELD_AMP),
        .chan         ('0),
        .data         ('0),
        .load         (swapping),
        .load_amps    (sh_amps),
        .load_offsets (sh_offsets),
        .load_phases  (sh_phases),
        .amps         (lv_amps),
        .offsets      (lv_offsets),
        .phases       (lv_phases)
    );

    // Enable bits: shadow written by control field, live copied at swap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_en <= 1'b0;
            live_en   <= 1'b0;
        end else begin
            if (accept && (wr_field == FIELD_CTRL))
                shadow_en <= wr_data[0];
            if (swapping)
                live_en <= shadow_en;
        end
    end

    // Sequencer: commits ignored while draining or swapping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (commit)
                        state <= ST_SWAP;
                end
                ST_RUN: begin
                    if (commit) begin
                        state <= ST_DRAIN;
                        cnt   <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (cnt == DRAIN_LAST) begin
                        state <= ST_SWAP;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    state <= shadow_en ? ST_RUN : ST_IDLE;
                end
            endcase
        end
    end

    assign active     = (state == ST_RUN) && live_en;
    assign busy       = (state == ST_DRAIN) || (state == ST_SWAP);
    assign amps       = lv_amps;
    assign offsets    = lv_offsets;
    assign phasewords = lv_phases;

`ifdef PARAM_READBACK_EN
    // Registered readback of one live word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            case (rd_field)
                FIELD_AMP:    rd_data <= lv_amps[word_base(rd_chan) +: WORD_W];
                FIELD_OFFSET: rd_data <= lv_offsets[word_base(rd_chan) +: WORD_W];
                FIELD_PHASE:  rd_data <= lv_phases[word_base(rd_chan) +: WORD_W];
                default:      rd_data <= {15'b0, live_en};
            endcase
        end
    end
`endif

endmodule
